// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the fetch/data memory bus arbiter.
// Build option MEM_ARB_RR_EN (round-robin grant) is handled in mem_arb_pick.
package mem_bus_arbiter_pkg;

    // Arbiter FSM state codes
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    // Bus owner: instruction fetch or MEM-stage data port
    typedef enum logic {
        ARB_OWNER_I = 1'b0,
        ARB_OWNER_D = 1'b1
    } arb_owner_e;

    // Chip-enable / write-enable levels shared with the rest of the core
    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester ports, pipeline flush and SRAM-style bus of the memory arbiter.
// The arbiter connects through modport master; the pipeline/memory side uses slave.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic              flush;
    // fetch port (read-only)
    logic              i_ce;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_stall;
    // data port
    logic              d_ce;
    logic              d_we;
    logic [SEL_W-1:0]  d_sel;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;
    // memory bus
    logic              bus_req;
    logic              bus_we;
    logic [SEL_W-1:0]  bus_sel;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        input  flush,
        input  i_ce, i_addr,
        output i_rdata, i_stall,
        input  d_ce, d_we, d_sel, d_addr, d_wdata,
        output d_rdata, d_stall,
        output bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        output flush,
        output i_ce, i_addr,
        input  i_rdata, i_stall,
        output d_ce, d_we, d_sel, d_addr, d_wdata,
        input  d_rdata, d_stall,
        input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );

endinterface

// File: rtl/mem_bus_arbiter_pick.sv
// mem_arb_pick: combinational owner selection for the memory bus arbiter.
// MEM_ARB_RR_EN defined: both requesting -> grant the port that was not served last.
// MEM_ARB_RR_EN undefined: fixed priority, data over fetch; 'last' is ignored and
// the register feeding it has no load.
module mem_arb_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic       i_ce,
    input  logic       d_ce,
    input  arb_owner_e last,
    output arb_owner_e owner
);

`ifdef MEM_ARB_RR_EN
    // Round-robin between two requesters; a lone requester always wins
    always_comb begin
        owner = ARB_OWNER_D;
        if (i_ce && d_ce) begin
            owner = (last == ARB_OWNER_I) ? ARB_OWNER_D : ARB_OWNER_I;
        end else if (i_ce) begin
            owner = ARB_OWNER_I;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    // Fixed priority: fetch only wins when data is not requesting
    always_comb begin
        owner = ARB_OWNER_D;
        if (i_ce && !d_ce) begin
            owner = ARB_OWNER_I;
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one SRAM-style bus between instruction fetch and MEM-stage data.
// IDLE grants one requester and registers the bus; REQ holds it until bus_ack;
// DONE returns data and releases the owner's stall for one cycle.
// Optional round-robin grant via MEM_ARB_RR_EN (see mem_arb_pick).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    mem_bus_arbiter_if.master m
);
    localparam int SEL_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    arb_owner_e        last_q, last_d;
    arb_owner_e        pick_owner;
    logic              drop_q, drop_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              any_ce;
    logic              done_i, done_d;

    assign any_ce = (m.i_ce == CHIP_ENABLE) || (m.d_ce == CHIP_ENABLE);

    mem_arb_pick u_pick (
        .i_ce  (m.i_ce),
        .d_ce  (m.d_ce),
        .last  (last_q),
        .owner (pick_owner)
    );

    // Next-state, bus register and read-data capture logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        drop_d      = drop_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_ce) begin
                    owner_d   = pick_owner;
                    bus_req_d = CHIP_ENABLE;
                    state_d   = ARB_REQ;
                    if (pick_owner == ARB_OWNER_D) begin
                        bus_we_d    = m.d_we;
                        bus_sel_d   = m.d_sel;
                        bus_addr_d  = m.d_addr;
                        bus_wdata_d = m.d_wdata;
                    end else begin
                        bus_we_d    = WRITE_DISABLE;
                        bus_sel_d   = '1;
                        bus_addr_d  = m.i_addr;
                        bus_wdata_d = '0;
                    end
                end
            end
            ARB_REQ: begin
                // A flush anywhere in REQ, including the ack cycle, discards the result
                drop_d = drop_q | m.flush;
                if (m.bus_ack) begin
                    rdata_d     = m.bus_rdata;
                    bus_req_d   = CHIP_DISABLE;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = '0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                    if (drop_q || m.flush) begin
                        state_d = ARB_IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = ARB_DONE;
                    end
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
                last_d  = owner_q;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and bus registers; reset drops the bus request immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= ARB_OWNER_I;
            last_q      <= ARB_OWNER_I;
            drop_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            drop_q      <= drop_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign done_i = (state_q == ARB_DONE) && (owner_q == ARB_OWNER_I);
    assign done_d = (state_q == ARB_DONE) && (owner_q == ARB_OWNER_D);

    assign m.i_stall   = m.i_ce & ~done_i & ~m.flush;
    assign m.d_stall   = m.d_ce & ~done_d & ~m.flush;
    assign m.i_rdata   = rdata_q;
    assign m.d_rdata   = rdata_q;
    assign m.bus_req   = bus_req_q;
    assign m.bus_we    = bus_we_q;
    assign m.bus_sel   = bus_sel_q;
    assign m.bus_addr  = bus_addr_q;
    assign m.bus_wdata = bus_wdata_q;

endmodule
